// File: rtl/cra_seq_pkg.sv
// Shared constants and enums for the microcode next-address sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cra_seq_pkg;

  localparam int AW_DEF    = 11;
  localparam int SD_DEF    = 16;
  localparam int NDISP_DEF = 8;

  // Which source drives the next CRAM address
  typedef enum logic [1:0] {
    SRC_DIAG,
    SRC_FORCE,
    SRC_SEQ
  } nxt_src_t;

  // Operation applied to the call/return stack this microcycle
  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } stack_op_t;

endpackage

// File: rtl/cra_seq_stack.sv
// Circular LIFO of return addresses with occupancy and overflow/underflow pulses.
// Latency: op takes effect at the next clk edge; top/cnt are combinational from state.
// Backpressure: none; full pushes overwrite the oldest entry, empty pops are no-ops.
module cra_seq_stack
  import cra_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int SD = SD_DEF
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  stack_op_t            op,
  input  logic [AW-1:0]        wdat,
  output logic [AW-1:0]        top,
  output logic [$clog2(SD):0]  cnt,
  output logic                 ovf,
  output logic                 unf
);

  localparam int PW = $clog2(SD);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [SD];
  logic [PW-1:0] wp;
  logic [PW-1:0] tp;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;

  // Decode the requested op against current occupancy
  always_comb begin
    tp      = wp - PW'(1);
    full    = (cnt == CW'(SD));
    empty   = (cnt == '0);
    // Replace on an empty stack degenerates to a push
    do_push = (op == OP_PUSH) || ((op == OP_REPL) && empty);
    do_pop  = (op == OP_POP) && !empty;
    do_repl = (op == OP_REPL) && !empty;
    ovf     = do_push && full;
    unf     = (op == OP_POP) && empty;
    top     = empty ? '0 : mem[tp];
  end

  // Entry storage; contents need no reset because an empty stack masks them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wdat;
    end else if (do_repl) begin
      mem[tp] <= wdat;
    end
  end

  // Write pointer and occupancy; a full push wraps onto the oldest slot
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wp  <= '0;
      cnt <= '0;
    end else if (do_push) begin
      wp <= wp + PW'(1);
      if (!full) begin
        cnt <= cnt + CW'(1);
      end
    end else if (do_pop) begin
      wp  <= tp;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/cra_seq.sv
// Microcode next-address sequencer: OR-merge of J/dispatch/skip/return with diag and trap override.
// Latency: one microcycle from sampled inputs (adv=1) to CRADR.
// Backpressure: adv=0 holds address, stack and flags; errClr still clears flags.
// Optional sticky stack error flags are built when CRA_SEQ_STACK_CHECK_EN is defined.
module cra_seq
  import cra_seq_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int SD    = SD_DEF,
  parameter int NDISP = NDISP_DEF
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       adv,
  input  logic [AW-1:0]              J,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       dispEn,
  input  logic [$clog2(NDISP)-1:0]   dispSel,
  input  logic [NDISP*AW-1:0]        dispSrc,
  input  logic                       skipEn,
  input  logic                       skipCond,
  input  logic                       forceTrap,
  input  logic                       diagLoad,
  input  logic [AW-1:0]              diagAdr,
  input  logic                       errClr,
  output logic [AW-1:0]              CRADR,
  output logic [AW-1:0]              loc,
  output logic [AW-1:0]              sbrRet,
  output logic [$clog2(SD):0]        stackCnt,
  output logic                       stackOvf,
  output logic                       stackUnf
);

  localparam int DSW = $clog2(NDISP);

  logic [AW-1:0] disp_dat;
  logic [AW-1:0] seq_adr;
  logic [AW-1:0] nxt_adr;
  logic [AW-1:0] push_dat;
  nxt_src_t      src;
  stack_op_t     op;
  logic          ovf_pulse;
  logic          unf_pulse;

  // Dispatch source select
  always_comb begin
    disp_dat = '0;
    for (int k = 0; k < NDISP; k++) begin
      if (dispSel == DSW'(k)) begin
        disp_dat = dispSrc[k*AW +: AW];
      end
    end
  end

  // Normal next address: pure bitwise OR of all contributing fields
  always_comb begin
    seq_adr = J
            | (dispEn ? disp_dat : '0)
            | {{(AW-1){1'b0}}, skipEn & skipCond}
            | (ret ? sbrRet : '0);
  end

  // Next-address priority: diagnostic load, then trap, then sequential
  always_comb begin
    src = SRC_SEQ;
    if (diagLoad) begin
      src = SRC_DIAG;
    end else if (forceTrap) begin
      src = SRC_FORCE;
    end
    case (src)
      SRC_DIAG:  nxt_adr = diagAdr;
      SRC_FORCE: nxt_adr = '1;
      default:   nxt_adr = seq_adr;
    endcase
  end

  // Stack op decode; a trap pushes the address it pre-empted so ret resumes there
  always_comb begin
    op       = OP_NONE;
    push_dat = CRADR;
    if (adv && !diagLoad) begin
      if (forceTrap) begin
        op       = OP_PUSH;
        push_dat = seq_adr;
      end else begin
        case ({call, ret})
          2'b10:   op = OP_PUSH;
          2'b01:   op = OP_POP;
          2'b11:   op = OP_REPL;
          default: op = OP_NONE;
        endcase
      end
    end
  end

  cra_seq_stack #(
    .AW (AW),
    .SD (SD)
  ) u_stack (
    .clk    (clk),
    .resetN (resetN),
    .op     (op),
    .wdat   (push_dat),
    .top    (sbrRet),
    .cnt    (stackCnt),
    .ovf    (ovf_pulse),
    .unf    (unf_pulse)
  );

  // Current and previous CRAM address registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      CRADR <= '0;
      loc   <= '0;
    end else if (adv) begin
      CRADR <= nxt_adr;
      loc   <= CRADR;
    end
  end

`ifdef CRA_SEQ_STACK_CHECK_EN
  // Sticky stack error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stackOvf <= 1'b0;
      stackUnf <= 1'b0;
    end else begin
      if (ovf_pulse) begin
        stackOvf <= 1'b1;
      end else if (errClr) begin
        stackOvf <= 1'b0;
      end
      if (unf_pulse) begin
        stackUnf <= 1'b1;
      end else if (errClr) begin
        stackUnf <= 1'b0;
      end
    end
  end
`else
  logic unused_err;
  assign unused_err = errClr ^ ovf_pulse ^ unf_pulse;
  assign stackOvf   = 1'b0;
  assign stackUnf   = 1'b0;
`endif

endmodule

// File: tb/tb_cra_seq.sv
// Directed bench for cra_seq with hand-computed expectations.
// Latency: checks sample 2 time units after each rising edge.
// Backpressure: exercises adv=0 hold and errClr while held.
module tb_cra_seq;
  import cra_seq_pkg::*;

  localparam int AW    = 11;
  localparam int SD    = 16;
  localparam int NDISP = 8;
`ifdef CRA_SEQ_STACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic                     clk;
  logic                     resetN;
  logic                     adv;
  logic [AW-1:0]            J;
  logic                     call;
  logic                     ret;
  logic                     dispEn;
  logic [$clog2(NDISP)-1:0] dispSel;
  logic [NDISP*AW-1:0]      dispSrc;
  logic                     skipEn;
  logic                     skipCond;
  logic                     forceTrap;
  logic                     diagLoad;
  logic [AW-1:0]            diagAdr;
  logic                     errClr;
  logic [AW-1:0]            CRADR;
  logic [AW-1:0]            loc;
  logic [AW-1:0]            sbrRet;
  logic [$clog2(SD):0]      stackCnt;
  logic                     stackOvf;
  logic                     stackUnf;

  int checks = 0;
  int errors = 0;

  cra_seq #(.AW(AW), .SD(SD), .NDISP(NDISP)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .adv       (adv),
    .J         (J),
    .call      (call),
    .ret       (ret),
    .dispEn    (dispEn),
    .dispSel   (dispSel),
    .dispSrc   (dispSrc),
    .skipEn    (skipEn),
    .skipCond  (skipCond),
    .forceTrap (forceTrap),
    .diagLoad  (diagLoad),
    .diagAdr   (diagAdr),
    .errClr    (errClr),
    .CRADR     (CRADR),
    .loc       (loc),
    .sbrRet    (sbrRet),
    .stackCnt  (stackCnt),
    .stackOvf  (stackOvf),
    .stackUnf  (stackUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    adv       = 1'b1;
    J         = '0;
    call      = 1'b0;
    ret       = 1'b0;
    dispEn    = 1'b0;
    dispSel   = '0;
    skipEn    = 1'b0;
    skipCond  = 1'b0;
    forceTrap = 1'b0;
    diagLoad  = 1'b0;
    diagAdr   = '0;
    errClr    = 1'b0;
  endtask

  initial begin
    resetN  = 1'b0;
    dispSrc = '0;
    idle();
    adv = 1'b0;
    #12;
    chk("rst_cradr", 32'(CRADR), 32'h0);
    chk("rst_loc", 32'(loc), 32'h0);
    chk("rst_cnt", 32'(stackCnt), 32'h0);
    chk("rst_sbr", 32'(sbrRet), 32'h0);
    chk("rst_ovf", 32'(stackOvf), 32'h0);
    chk("rst_unf", 32'(stackUnf), 32'h0);
    resetN = 1'b1;
    #1;

    // J only
    idle();
    J = 11'h123;
    tick();
    chk("j_cradr", 32'(CRADR), 32'h123);
    chk("j_loc", 32'(loc), 32'h0);

    // Dispatch OR from source 3 (source 2 set to catch a wrong select)
    dispSrc[3*AW +: AW] = 11'h00F;
    dispSrc[2*AW +: AW] = 11'h400;
    J = 11'h200; dispEn = 1'b1; dispSel = 3'd3;
    tick();
    chk("disp_cradr", 32'(CRADR), 32'h20F);
    chk("disp_loc", 32'(loc), 32'h123);

    // Skip bit
    idle();
    J = 11'h100; skipEn = 1'b1; skipCond = 1'b1;
    tick();
    chk("skip_on", 32'(CRADR), 32'h101);
    skipEn = 1'b0;
    tick();
    chk("skip_off", 32'(CRADR), 32'h100);

    // Call then return
    idle();
    J = 11'h040;
    tick();
    call = 1'b1; J = 11'h080;
    tick();
    chk("call_cradr", 32'(CRADR), 32'h080);
    chk("call_cnt", 32'(stackCnt), 32'h1);
    chk("call_sbr", 32'(sbrRet), 32'h040);
    idle();
    ret = 1'b1; J = 11'h001;
    tick();
    chk("ret_cradr", 32'(CRADR), 32'h041);
    chk("ret_cnt", 32'(stackCnt), 32'h0);
    chk("ret_sbr", 32'(sbrRet), 32'h0);

    // Trap while returning
    idle();
    J = 11'h100;
    tick();
    call = 1'b1; J = 11'h000;
    tick();
    idle();
    J = 11'h050; ret = 1'b1; forceTrap = 1'b1;
    tick();
    chk("trap_cradr", 32'(CRADR), 32'h7FF);
    chk("trap_cnt", 32'(stackCnt), 32'h2);
    chk("trap_sbr", 32'(sbrRet), 32'h150);
    idle();
    ret = 1'b1;
    tick();
    chk("trap_pop1", 32'(CRADR), 32'h150);
    chk("trap_pop1_cnt", 32'(stackCnt), 32'h1);
    tick();
    chk("trap_pop2", 32'(CRADR), 32'h100);
    chk("trap_pop2_cnt", 32'(stackCnt), 32'h0);

    // Overflow: 17 calls from addresses 1..17
    idle();
    J = 11'd1;
    tick();
    for (int i = 2; i <= 18; i++) begin
      call = 1'b1; J = AW'(i);
      tick();
    end
    chk("ovf_cnt", 32'(stackCnt), 32'd16);
    chk("ovf_flag", 32'(stackOvf), 32'(CHK));
    chk("ovf_unf", 32'(stackUnf), 32'h0);
    chk("ovf_sbr", 32'(sbrRet), 32'd17);
    idle();
    ret = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("pop_sbr", 32'(sbrRet), 32'(17 - k));
      tick();
      chk("pop_cradr", 32'(CRADR), 32'(17 - k));
    end
    chk("pop_cnt", 32'(stackCnt), 32'h0);
    idle();
    errClr = 1'b1;
    tick();
    chk("ovf_clr", 32'(stackOvf), 32'h0);

    // Pop on an empty stack
    idle();
    ret = 1'b1; J = 11'h010;
    tick();
    chk("unf_cradr", 32'(CRADR), 32'h010);
    chk("unf_flag", 32'(stackUnf), 32'(CHK));
    chk("unf_cnt", 32'(stackCnt), 32'h0);
    // errClr acts while held
    idle();
    adv = 1'b0; errClr = 1'b1;
    tick();
    chk("unf_clr_hold", 32'(stackUnf), 32'h0);
    chk("unf_hold_cradr", 32'(CRADR), 32'h010);
    // New error and clear on the same edge: error wins
    idle();
    ret = 1'b1; errClr = 1'b1; J = 11'h010;
    tick();
    chk("unf_vs_clr", 32'(stackUnf), 32'(CHK));
    idle();
    errClr = 1'b1; J = 11'h010;
    tick();

    // Diagnostic load beats call and trap; stack untouched
    idle();
    call = 1'b1; J = 11'h020;
    tick();
    idle();
    diagLoad = 1'b1; diagAdr = 11'h3AA; call = 1'b1; forceTrap = 1'b1; J = 11'h005;
    tick();
    chk("diag_cradr", 32'(CRADR), 32'h3AA);
    chk("diag_loc", 32'(loc), 32'h020);
    chk("diag_cnt", 32'(stackCnt), 32'h1);
    chk("diag_sbr", 32'(sbrRet), 32'h010);

    // Hold for three cycles with busy inputs
    idle();
    adv = 1'b0; call = 1'b1; forceTrap = 1'b1; J = 11'h777;
    tick(); tick(); tick();
    chk("hold_cradr", 32'(CRADR), 32'h3AA);
    chk("hold_loc", 32'(loc), 32'h020);
    chk("hold_cnt", 32'(stackCnt), 32'h1);
    chk("hold_sbr", 32'(sbrRet), 32'h010);

    // Call and return together replace the top entry
    idle();
    call = 1'b1; ret = 1'b1;
    tick();
    chk("repl_cradr", 32'(CRADR), 32'h010);
    chk("repl_cnt", 32'(stackCnt), 32'h1);
    chk("repl_sbr", 32'(sbrRet), 32'h3AA);

    // Asynchronous reset mid-cycle
    idle();
    #1;
    resetN = 1'b0;
    #1;
    chk("arst_cradr", 32'(CRADR), 32'h0);
    chk("arst_loc", 32'(loc), 32'h0);
    chk("arst_cnt", 32'(stackCnt), 32'h0);
    chk("arst_sbr", 32'(sbrRet), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cra_seq.md
# cra_seq

Parametrised microcode next-address sequencer. It is the successor to the fixed 2K-word CRAM address logic. It registers the control-RAM address each microcycle from the J field, an N-way dispatch OR-mux, a skip bit, a forced-trap address and a diagnostic load. It also adds a true LIFO call/return stack of configurable depth with occupancy reporting. It sits between the CRAM output fields and the CRAM address input, in the same position as the existing CRA.

## Interface
- `AW`, 11: CRAM address width (2^AW words).
- `SD`, 16: call/return stack depth; power of two, ≥2.
- `NDISP`, 8: number of dispatch sources.

- `clk`  in  1  microcycle clock
- `resetN`  in  1  asynchronous, active-low reset
- `adv`  in  1  advance; 0 holds all state
- `J`  in  AW  CRAM J field
- `call`  in  1  push return address
- `ret`  in  1  pop; OR top-of-stack into next address
- `dispEn`  in  1  enable dispatch OR
- `dispSel`  in  $clog2(NDISP)  dispatch source select
- `dispSrc`  in  NDISP*AW  dispatch sources, source k at bits [k*AW +: AW]
- `skipEn`  in  1  enable skip
- `skipCond`  in  1  skip condition, ORed into bit 0
- `force`  in  1  trap: force all-ones address
- `diagLoad`  in  1  diagnostic address load
- `diagAdr`  in  AW  diagnostic address
- `errClr`  in  1  clear sticky stack errors
- `CRADR`  out  AW  current CRAM address (registered)
- `loc`  out  AW  previous CRADR
- `sbrRet`  out  AW  top-of-stack; 0 when empty
- `stackCnt`  out  $clog2(SD)+1  stack occupancy 0..SD
- `stackOvf`  out  1  sticky push-when-full
- `stackUnf`  out  1  sticky pop-when-empty

## Operation
- `seqAdr` is the normal next address: `J | (dispEn ? dispSrc[dispSel] : 0) | {0…, skipEn & skipCond} | (ret ? sbrRet : 0)`. There is no arithmetic; all merging is bitwise OR.
- Next-address priority:
  1. `diagLoad`: next = `diagAdr`; the stack is untouched.
  2. `force`: next = all ones. `seqAdr` is pushed so that a return resumes the interrupted flow. `ret` is suppressed and `call` is ignored.
  3. Otherwise: next = `seqAdr`.
- Stack actions without force or diagLoad:
  - `call` only: push `CRADR`.
  - `ret` only: pop.
  - `call` and `ret` together: the top entry is replaced by `CRADR` and occupancy is unchanged. If the stack is empty, this is a push, and `sbrRet` reads 0 for the OR.
- The stack is circular with a write pointer of $clog2(SD) bits.
  - Push when full (`stackCnt`==SD): the oldest entry is overwritten, the count stays at SD, and `stackOvf` is set.
  - Pop when empty: `sbrRet`=0, the count stays 0, the pointer is unchanged, and `stackUnf` is set.
- `loc` takes the old `CRADR` whenever `CRADR` updates.
- Reset values: `CRADR`=0, `loc`=0, `stackCnt`=0, `sbrRet`=0, `stackOvf`=0, `stackUnf`=0. Stack RAM contents are don't-care, because an empty stack masks them.

## Timing
- One-cycle latency: inputs sampled at a `clk` rising edge with `adv`=1 set `CRADR` after that edge.
- `sbrRet` and `stackCnt` are combinational from registered state. They are valid in the same cycle in which they are ORed or used.
- `adv`=0: `CRADR`, `loc`, the stack, and the flags all hold. `errClr` still acts.
- `errClr` clears flags on the next edge. If `errClr` and a new error occur in the same edge, the flag ends up set.
- `resetN` low mid-cycle clears all registers immediately, with no clock required. Release is synchronised externally.

## Configuration
- `CRA_SEQ_STACK_CHECK_EN` defined: `stackOvf` and `stackUnf` are implemented as above.
- Not defined: both flags are tied 0 and `errClr` is ignored. Wrap and empty-pop behaviour is otherwise identical.

## Structure
- Package `cra_seq_pkg`: default `AW`/`SD`/`NDISP` constants; a next-address source enum (`SRC_DIAG`, `SRC_FORCE`, `SRC_SEQ`); a stack-op enum (`OP_NONE`, `OP_PUSH`, `OP_POP`, `OP_REPL`).
- Sub-module `cra_seq_stack`: circular LIFO with pointer, count, top-of-stack read, and overflow/underflow pulses. It is parametrised by `AW` and `SD`.
- The top level holds the priority mux, the OR merge, the `CRADR`/`loc` registers and the sticky flags.

## Test plan
- Reset, then `J`=0x123 with `adv`=1 → `CRADR`=0x123 after one edge and `loc`=0. Then `J`=0x200 with `dispEn`=1 and `dispSrc[3]`=0x00F selected → `CRADR`=0x20F.
- Call then return: at `CRADR`=0x040, `call`=1 → `stackCnt`=1 and `sbrRet`=0x040. Later, `ret`=1 with `J`=0x001 → `CRADR`=0x041 and `stackCnt`=0.
- Force during `ret`: stack holds 0x100, `J`=0x050, `ret`=1, `force`=1 → `CRADR`=0x7FF (AW=11) and `stackCnt`=2. The top now holds 0x150, the pre-force `seqAdr` including the ORed 0x100 from the suppressed `ret`.
- Overflow with SD=16: 17 consecutive calls from addresses 1..17 → `stackCnt`=16, `stackOvf`=1 (macro on), and 16 pops return 17 down to 2. `errClr` → `stackOvf`=0.
- Empty pop: `ret`=1 with `J`=0x010 on an empty stack → `CRADR`=0x010, `stackUnf`=1 with the macro and 0 without it.
- `diagLoad`=1 with `diagAdr`=0x3AA alongside `call` and `force` → `CRADR`=0x3AA and the stack is unchanged. `adv`=0 for 3 cycles → all outputs hold. Assert `resetN` mid-run → all outputs are 0 before the next edge.
